// File: rtl/addition_stage3.sv
// Mantissa add/subtract stage of a floating-point adder, with a registered output and a one-entry skid buffer.
// Optional macro ADDITION_STAGE3_COUNT_EN enables the 16-bit saturating output-transfer counter.
module addition_stage3 #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MENT_WIDTH-1:0] larger_operand_in,
    input  logic [MENT_WIDTH-1:0] smaller_operand_in,
    input  logic                  smaller_hidden_in,
    input  logic                  sign_large_in,
    input  logic                  sign_small_in,
    input  logic [EXPO_WIDTH-1:0] exponent_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MENT_WIDTH+1:0] sum_out,
    output logic                  sign_out,
    output logic                  zero_out,
    output logic [EXPO_WIDTH-1:0] exponent_out,
    output logic [15:0]           xfer_count_out
);

    localparam int SW = MENT_WIDTH + 2;

    logic [SW-1:0]         op_a;
    logic [SW-1:0]         op_b;
    logic [SW-1:0]         new_sum;
    logic                  new_sign;
    logic                  new_zero;

    logic                  skid_valid;
    logic [SW-1:0]         skid_sum;
    logic                  skid_sign;
    logic                  skid_zero;
    logic [EXPO_WIDTH-1:0] skid_exponent;

    logic                  in_xfer;
    logic                  out_xfer;

    assign in_ready = ~skid_valid & ~rst;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Signed-magnitude add: the larger-exponent operand carries the implicit hidden 1.
    always_comb begin
        op_a     = {2'b01, larger_operand_in};
        op_b     = {1'b0, smaller_hidden_in, smaller_operand_in};
        new_sum  = '0;
        new_sign = sign_large_in;
        if (sign_large_in == sign_small_in) begin
            new_sum = op_a + op_b;
        end else if (op_a >= op_b) begin
            new_sum = op_a - op_b;
        end else begin
            new_sum  = op_b - op_a;
            new_sign = ~sign_large_in;
        end
        new_zero = (new_sum == '0);
        if (new_zero) begin
            new_sign = 1'b0;
        end
    end

    // Output register refills from the skid entry first so results leave in arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            sum_out      <= '0;
            sign_out     <= 1'b0;
            zero_out     <= 1'b0;
            exponent_out <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid    <= 1'b1;
                sum_out      <= skid_sum;
                sign_out     <= skid_sign;
                zero_out     <= skid_zero;
                exponent_out <= skid_exponent;
            end else if (in_xfer) begin
                out_valid    <= 1'b1;
                sum_out      <= new_sum;
                sign_out     <= new_sign;
                zero_out     <= new_zero;
                exponent_out <= exponent_in;
            end else begin
                out_valid    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid    <= 1'b0;
            skid_sum      <= '0;
            skid_sign     <= 1'b0;
            skid_zero     <= 1'b0;
            skid_exponent <= '0;
        end else if (skid_valid && out_xfer) begin
            skid_valid    <= 1'b0;
        end else if (in_xfer && out_valid && !out_ready) begin
            skid_valid    <= 1'b1;
            skid_sum      <= new_sum;
            skid_sign     <= new_sign;
            skid_zero     <= new_zero;
            skid_exponent <= exponent_in;
        end
    end

`ifdef ADDITION_STAGE3_COUNT_EN
    logic [15:0] xfer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (out_xfer && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end

    assign xfer_count_out = xfer_count;
`else
    assign xfer_count_out = '0;
`endif

endmodule

// File: tb/tb_addition_stage3.sv
// Directed-vector testbench for addition_stage3: table of single transfers plus backpressure and reset sequences.
module tb_addition_stage3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] larger_operand_in;
    logic [22:0] smaller_operand_in;
    logic        smaller_hidden_in;
    logic        sign_large_in;
    logic        sign_small_in;
    logic [7:0]  exponent_in;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] sum_out;
    logic        sign_out;
    logic        zero_out;
    logic [7:0]  exponent_out;
    logic [15:0] xfer_count_out;

    int total = 0;
    int bad   = 0;

    addition_stage3 dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .larger_operand_in  (larger_operand_in),
        .smaller_operand_in (smaller_operand_in),
        .smaller_hidden_in  (smaller_hidden_in),
        .sign_large_in      (sign_large_in),
        .sign_small_in      (sign_small_in),
        .exponent_in        (exponent_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .sum_out            (sum_out),
        .sign_out           (sign_out),
        .zero_out           (zero_out),
        .exponent_out       (exponent_out),
        .xfer_count_out     (xfer_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sl;
        logic        ss;
        logic [22:0] l;
        logic [22:0] s;
        logic        h;
        logic [7:0]  e;
        logic [24:0] sum;
        logic        sign;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    task automatic applyStimulus(input logic v, input logic sl, input logic ss,
                                 input logic [22:0] l, input logic [22:0] s,
                                 input logic h, input logic [7:0] e);
        in_valid           = v;
        sign_large_in      = sl;
        sign_small_in      = ss;
        larger_operand_in  = l;
        smaller_operand_in = s;
        smaller_hidden_in  = h;
        exponent_in        = e;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in: signs, L, S, hidden, exp; out: sum, sign, zero
        vecs[0] = '{1'b0, 1'b0, 23'h000000, 23'h000000, 1'b1, 8'h80, 25'h1000000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 23'h000000, 23'h000000, 1'b1, 8'h7F, 25'h1000000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 23'h400000, 23'h400000, 1'b1, 8'h81, 25'h0000000, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 23'h000000, 23'h400000, 1'b1, 8'h82, 25'h0400000, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 23'h7FFFFF, 23'h000001, 1'b0, 8'hFF, 25'h0FFFFFE, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 23'h7FFFFF, 23'h7FFFFF, 1'b1, 8'h00, 25'h1FFFFFE, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 23'h123456, 23'h012345, 1'b0, 8'h55, 25'h093579B, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 23'h100000, 23'h200000, 1'b1, 8'h3C, 25'h0100000, 1'b0, 1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 23'h0, 23'h0, 1'b0, 8'h0);
        tick();
        tick();
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset sum_out", {7'b0, sum_out}, 32'd0);
        checkOutput("reset count", {16'b0, xfer_count_out}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].sl, vecs[i].ss, vecs[i].l, vecs[i].s, vecs[i].h, vecs[i].e);
            tick();
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d sum", i), {7'b0, sum_out}, {7'b0, vecs[i].sum});
            checkOutput($sformatf("vec%0d sign", i), {31'b0, sign_out}, {31'b0, vecs[i].sign});
            checkOutput($sformatf("vec%0d zero", i), {31'b0, zero_out}, {31'b0, vecs[i].zero});
            checkOutput($sformatf("vec%0d exp", i), {24'b0, exponent_out}, {24'b0, vecs[i].e});
        end
        tick();
        checkOutput("drained out_valid", {31'b0, out_valid}, 32'd0);
`ifdef ADDITION_STAGE3_COUNT_EN
        checkOutput("count after table", {16'b0, xfer_count_out}, 32'd8);
`else
        checkOutput("count after table", {16'b0, xfer_count_out}, 32'd0);
`endif

        // Backpressure: three inputs offered while downstream stalls.
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 23'h000000, 23'h0, 1'b0, 8'h11);
        tick();
        checkOutput("bp first accepted", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 23'h000001, 23'h0, 1'b0, 8'h22);
        tick();
        checkOutput("bp in_ready after second", {31'b0, in_ready}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 23'h000002, 23'h0, 1'b0, 8'h33);
        tick();
        tick();
        checkOutput("bp still stalled", {31'b0, in_ready}, 32'd0);
        checkOutput("bp hold sum", {7'b0, sum_out}, 32'h0800000);
        checkOutput("bp hold exp", {24'b0, exponent_out}, 32'h11);
        out_ready = 1'b1;
        tick();
        checkOutput("bp second out", {7'b0, sum_out}, 32'h0800001);
        checkOutput("bp second exp", {24'b0, exponent_out}, 32'h22);
        checkOutput("bp skid freed", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp third out", {7'b0, sum_out}, 32'h0800002);
        checkOutput("bp third valid", {31'b0, out_valid}, 32'd1);
        tick();
        checkOutput("bp empty", {31'b0, out_valid}, 32'd0);

        // Reset while both output register and skid hold data.
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 23'h000005, 23'h0, 1'b0, 8'h44);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 23'h000006, 23'h0, 1'b0, 8'h45);
        tick();
        in_valid = 1'b0;
        checkOutput("pre-rst skid full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst sum", {7'b0, sum_out}, 32'd0);
        checkOutput("rst exp", {24'b0, exponent_out}, 32'd0);
        checkOutput("rst count", {16'b0, xfer_count_out}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst release in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("no stale result", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].sl, vecs[i].ss, vecs[i].l, vecs[i].s, vecs[i].h, vecs[i].e);
            tick();
        end
        in_valid = 1'b0;
        tick();
`ifdef ADDITION_STAGE3_COUNT_EN
        checkOutput("count five", {16'b0, xfer_count_out}, 32'd5);
`else
        checkOutput("count five", {16'b0, xfer_count_out}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
